core_rf_sr_stack: RTL and testbench

- Parametrised status register: flags, processor mode and interrupt-enable bit, with a hardware shadow stack.
- The stack saves the full SR on exception entry and restores it on exception return, which allows nested exceptions up to DEPTH levels.
- Sits in the register-file stage beside the GPR file; ALU flags come in every cycle, and writeback and the exception unit drive the control inputs.

---
 rtl/core_rf_sr_stack.sv | 132 +++++++++++++
 tb/tb_core_rf_sr_stack.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_rf_sr_stack.sv
// Status register (flags, mode, interrupt enable) with a hardware shadow stack
// for nested exceptions. SR layout is {flag, mode, i}, with i at bit 0.
// Define SR_STACK_ERR_EN to get sticky overflow/underflow error registers.
// Without it, both error outputs are tied to 0.
module core_rf_sr_stack #(
  parameter int unsigned FLAG_W   = 4,
  parameter int unsigned MODE_W   = 2,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RST_MODE = 0,
  parameter int unsigned EXC_MODE = 1,
  localparam int unsigned SR_W    = FLAG_W + MODE_W + 1,
  localparam int unsigned DEP_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [FLAG_W-1:0] flag_i,
  input  logic              write_sr_i,
  input  logic [SR_W-1:0]   wb_sr_i,
  input  logic              write_mode_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              write_i_i,
  input  logic              i_i,
  input  logic              exc_entry_i,
  input  logic              exc_return_i,
  input  logic              err_clr_i,
  output logic [SR_W-1:0]   sr_o,
  output logic [DEP_W-1:0]  depth_o,
  output logic              stack_full_o,
  output logic              stack_empty_o,
  output logic              stack_ovf_o,
  output logic              stack_unf_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [MODE_W-1:0] RstModeV = MODE_W'(RST_MODE);
  localparam logic [MODE_W-1:0] ExcModeV = MODE_W'(EXC_MODE);

  logic [SR_W-1:0]  sr_q, sr_d;
  logic [DEP_W-1:0] depth_q, depth_d;
  logic [SR_W-1:0]  stack_q [DEPTH];

  logic             full, empty;
  logic             push_en;
  logic             ovf_set, unf_set;
  logic [IDX_W-1:0] push_idx, pop_idx;

  assign full     = (depth_q == DEP_W'(DEPTH));
  assign empty    = (depth_q == '0);
  assign push_idx = depth_q[IDX_W-1:0];
  assign pop_idx  = IDX_W'(depth_q - DEP_W'(1));

  // Next-SR selection and stack pointer update; exceptions take priority over writes.
  always_comb begin
    sr_d    = sr_q;
    depth_d = depth_q;
    push_en = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (exc_entry_i) begin
      // SR enters exception mode even when the push is refused.
      sr_d = {flag_i, ExcModeV, 1'b0};
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        push_en = 1'b1;
        depth_d = depth_q + DEP_W'(1);
      end
    end else if (exc_return_i) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        sr_d    = stack_q[pop_idx];
        depth_d = depth_q - DEP_W'(1);
      end
    end else if (write_sr_i) begin
      sr_d = wb_sr_i;
    end else begin
      sr_d = {flag_i,
              write_mode_i ? mode_i : sr_q[MODE_W:1],
              write_i_i ? i_i : sr_q[0]};
    end
  end

  // SR and depth registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q    <= {{FLAG_W{1'b0}}, RstModeV, 1'b0};
      depth_q <= '0;
    end else begin
      sr_q    <= sr_d;
      depth_q <= depth_d;
    end
  end

  // Stack storage; contents need no reset because depth alone marks validity.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_en) begin
      stack_q[push_idx] <= sr_q;
    end
  end

`ifdef SR_STACK_ERR_EN
  logic ovf_q, unf_q;

  // Sticky errors; a new error beats a coincident clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set)        ovf_q <= 1'b1;
      else if (err_clr_i) ovf_q <= 1'b0;
      if (unf_set)        unf_q <= 1'b1;
      else if (err_clr_i) unf_q <= 1'b0;
    end
  end

  assign stack_ovf_o = ovf_q;
  assign stack_unf_o = unf_q;
`else
  logic unused_err;
  assign unused_err  = err_clr_i ^ ovf_set ^ unf_set;
  assign stack_ovf_o = 1'b0;
  assign stack_unf_o = 1'b0;
`endif

  assign sr_o          = sr_q;
  assign depth_o       = depth_q;
  assign stack_full_o  = full;
  assign stack_empty_o = empty;

endmodule

// File: tb/tb_core_rf_sr_stack.sv
// Bench for core_rf_sr_stack at default parameters: a directed vector table,
// hand-written nesting/reset sequences and random stimulus against a queue model.
module tb_core_rf_sr_stack;

  localparam int unsigned Depth = 4;
`ifdef SR_STACK_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flag;
  logic       write_sr;
  logic [6:0] wb_sr;
  logic       write_mode;
  logic [1:0] mode;
  logic       write_i;
  logic       i_v;
  logic       exc_entry;
  logic       exc_return;
  logic       err_clr;
  logic [6:0] sr;
  logic [2:0] depth;
  logic       stack_full, stack_empty, stack_ovf, stack_unf;

  int n_checks = 0;
  int n_errors = 0;

  core_rf_sr_stack dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flag_i       (flag),
    .write_sr_i   (write_sr),
    .wb_sr_i      (wb_sr),
    .write_mode_i (write_mode),
    .mode_i       (mode),
    .write_i_i    (write_i),
    .i_i          (i_v),
    .exc_entry_i  (exc_entry),
    .exc_return_i (exc_return),
    .err_clr_i    (err_clr),
    .sr_o         (sr),
    .depth_o      (depth),
    .stack_full_o (stack_full),
    .stack_empty_o(stack_empty),
    .stack_ovf_o  (stack_ovf),
    .stack_unf_o  (stack_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] flag;
    logic       wsr;
    logic [6:0] wb;
    logic       wm;
    logic [1:0] md;
    logic       wi;
    logic       iv;
    logic       ent;
    logic       ret;
    logic       clr;
    logic [6:0] e_sr;
    logic [2:0] e_dep;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs[15];

  // Reference model: LIFO as a queue of saved SR values.
  logic [6:0] m_stack[$];
  logic [6:0] m_sr;
  logic       m_ovf, m_unf;

  task automatic model_step();
    logic n_ovf, n_unf;
    n_ovf = 1'b0;
    n_unf = 1'b0;
    if (rst) begin
      m_stack.delete();
      m_sr  = 7'h00;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (exc_entry) begin
        if (m_stack.size() < Depth) m_stack.push_back(m_sr);
        else n_ovf = 1'b1;
        m_sr = {flag, 2'd1, 1'b0};
      end else if (exc_return) begin
        if (m_stack.size() > 0) m_sr = m_stack.pop_back();
        else n_unf = 1'b1;
      end else if (write_sr) begin
        m_sr = wb_sr;
      end else begin
        m_sr = {flag, write_mode ? mode : m_sr[2:1], write_i ? i_v : m_sr[0]};
      end
      m_ovf = n_ovf ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
      m_unf = n_unf ? 1'b1 : (err_clr ? 1'b0 : m_unf);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [6:0] e_sr, input logic [2:0] e_dep,
                           input logic e_ovf, input logic e_unf);
    chk({tag, " sr"}, 32'(sr), 32'(e_sr));
    chk({tag, " depth"}, 32'(depth), 32'(e_dep));
    chk({tag, " full"}, 32'(stack_full), 32'(e_dep == 3'(Depth)));
    chk({tag, " empty"}, 32'(stack_empty), 32'(e_dep == 3'd0));
    chk({tag, " ovf"}, 32'(stack_ovf), 32'(e_ovf & ErrEn));
    chk({tag, " unf"}, 32'(stack_unf), 32'(e_unf & ErrEn));
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; flag = v.flag; write_sr = v.wsr; wb_sr = v.wb;
    write_mode = v.wm; mode = v.md; write_i = v.wi; i_v = v.iv;
    exc_entry = v.ent; exc_return = v.ret; err_clr = v.clr;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_vec(output vec_t v);
    v = '{rst: 1'b0, flag: 4'h0, wsr: 1'b0, wb: 7'h00, wm: 1'b0, md: 2'd0, wi: 1'b0, iv: 1'b0,
          ent: 1'b0, ret: 1'b0, clr: 1'b0, e_sr: 7'h00, e_dep: 3'd0, e_ovf: 1'b0, e_unf: 1'b0};
  endtask

  task automatic hand_step(input string tag, input logic r, input logic [3:0] f,
                           input logic en, input logic rt);
    vec_t v;
    idle_vec(v);
    v.rst = r; v.flag = f; v.ent = en; v.ret = rt;
    @(negedge clk);
    drive(v);
    tick();
    check_all(tag, m_sr, 3'(m_stack.size()), m_ovf, m_unf);
  endtask

  initial begin
    vec_t v;
    idle_vec(v);
    v.rst = 1'b1;
    drive(v);
    m_sr = 7'h00; m_ovf = 1'b0; m_unf = 1'b0;

    //              rst  flag  wsr  wb     wm  md  wi  iv  ent ret clr  sr     dep  ovf unf
    vecs[0]  = '{1'b1, 4'h0, 1'b1, 7'h7F, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 1'b1, 7'h7F, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'hA, 1'b0, 7'h00, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h57, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'h5, 1'b0, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h2F, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'h0, 1'b1, 7'h1D, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h1D, 3'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 1'b0, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h02, 3'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 1'b0, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h1D, 3'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'hF, 1'b1, 7'h7F, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h1D, 3'd0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 4'h3, 1'b0, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'h1D, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'h0, 1'b0, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'h1D, 3'd0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'h3, 1'b0, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'h1D, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'h3, 1'b0, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h1A, 3'd1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'h3, 1'b1, 7'h7F, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'h1A, 3'd2, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'h0, 1'b0, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h1A, 3'd1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'h0, 1'b0, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h1D, 3'd0, 1'b0, 1'b0};

    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      drive(vecs[k]);
      tick();
      check_all($sformatf("vec%0d", k), vecs[k].e_sr, vecs[k].e_dep, vecs[k].e_ovf, vecs[k].e_unf);
    end

    // Nest past capacity with distinct flags, unwind fully, then one extra return.
    hand_step("nest_rst", 1'b1, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) hand_step($sformatf("nest_ent%0d", k), 1'b0, 4'(k + 1), 1'b1, 1'b0);
    chk("nest_full_const", 32'(depth), 32'd4);
    chk("nest_ovf_const", 32'(stack_ovf), 32'(ErrEn));
    for (int k = 0; k < 5; k++) hand_step($sformatf("nest_ret%0d", k), 1'b0, 4'hE, 1'b0, 1'b1);
    chk("nest_unf_const", 32'(stack_unf), 32'(ErrEn));

    // Reset in the middle of nesting drops all saved entries.
    hand_step("mid_ent0", 1'b0, 4'h6, 1'b1, 1'b0);
    hand_step("mid_ent1", 1'b0, 4'h7, 1'b1, 1'b0);
    hand_step("mid_rst", 1'b1, 4'h7, 1'b1, 1'b0);
    hand_step("mid_ret", 1'b0, 4'h9, 1'b0, 1'b1);

    // Random traffic against the queue model.
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 59) == 0);
      flag       = 4'($urandom);
      write_sr   = ($urandom_range(0, 7) == 0);
      wb_sr      = 7'($urandom);
      write_mode = ($urandom_range(0, 3) == 0);
      mode       = 2'($urandom);
      write_i    = ($urandom_range(0, 3) == 0);
      i_v        = 1'($urandom);
      exc_entry  = ($urandom_range(0, 4) == 0);
      exc_return = ($urandom_range(0, 4) == 0);
      err_clr    = ($urandom_range(0, 7) == 0);
      tick();
      check_all($sformatf("rnd%0d", k), m_sr, 3'(m_stack.size()), m_ovf, m_unf);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
